// File: rtl/ss_ddram_responder.sv
// Savestate-to-DDRAM bridge: turns toggle-handshake word requests into single-beat DDRAM commands.
// Optional one-entry read cache enabled by defining SS_DDRAM_RDCACHE_EN.
module ss_ddram_responder #(
  parameter logic [28:0] BASE_ADDR = 29'h0600000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ss_req,
  output logic        ss_ack,
  input  logic        ss_we,
  input  logic [18:0] ss_addr,
  input  logic [7:0]  ss_be,
  input  logic [63:0] ss_din,
  output logic [63:0] ss_dout,
  input  logic        ddram_busy,
  output logic [28:0] ddram_addr,
  output logic [7:0]  ddram_burstcnt,
  output logic        ddram_rd,
  output logic        ddram_we,
  output logic [63:0] ddram_din,
  output logic [7:0]  ddram_be,
  input  logic [63:0] ddram_dout,
  input  logic        ddram_dout_ready
);

  localparam int unsigned AW  = 29;
  localparam int unsigned SAW = 19;
  localparam int unsigned DW  = 64;
  localparam int unsigned BEW = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_CMD  = 2'd1,
    RD_CMD  = 2'd2,
    RD_WAIT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             ack_q, ack_d;
  logic [DW-1:0]    dout_q, dout_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             rd_q, rd_d;
  logic             we_q, we_d;
  logic [DW-1:0]    din_q, din_d;
  logic [BEW-1:0]   be_q, be_d;

`ifdef SS_DDRAM_RDCACHE_EN
  logic             hit_q, hit_d;
  logic [SAW-1:0]   tag_q, tag_d;
  logic             cvalid_q, cvalid_d;
  logic [SAW-1:0]   ctag_q, ctag_d;
  logic [DW-1:0]    cdata_q, cdata_d;
`endif

  // Next-state and output decode
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    dout_d  = dout_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    we_d    = we_q;
    din_d   = din_q;
    be_d    = be_q;
`ifdef SS_DDRAM_RDCACHE_EN
    hit_d    = hit_q;
    tag_d    = tag_q;
    cvalid_d = cvalid_q;
    ctag_d   = ctag_q;
    cdata_d  = cdata_q;
`endif

    case (state_q)
      IDLE: begin
        if (ss_req != ack_q) begin
          addr_d = BASE_ADDR + AW'(ss_addr);
`ifdef SS_DDRAM_RDCACHE_EN
          tag_d = ss_addr;
`endif
          if (ss_we) begin
            we_d    = 1'b1;
            din_d   = ss_din;
            be_d    = ss_be;
            state_d = WR_CMD;
`ifdef SS_DDRAM_RDCACHE_EN
            cvalid_d = 1'b0;
`endif
          end else begin
            be_d = {BEW{1'b1}};
`ifdef SS_DDRAM_RDCACHE_EN
            // A hit skips DDRAM; RD_WAIT completes it on the next edge
            if (cvalid_q && (ctag_q == ss_addr)) begin
              hit_d   = 1'b1;
              state_d = RD_WAIT;
            end else begin
              hit_d   = 1'b0;
              rd_d    = 1'b1;
              state_d = RD_CMD;
            end
`else
            rd_d    = 1'b1;
            state_d = RD_CMD;
`endif
          end
        end
      end

      WR_CMD: begin
        if (!ddram_busy) begin
          we_d    = 1'b0;
          ack_d   = ~ack_q;
          state_d = IDLE;
        end
      end

      RD_CMD: begin
        if (!ddram_busy) begin
          rd_d    = 1'b0;
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
`ifdef SS_DDRAM_RDCACHE_EN
        if (hit_q) begin
          dout_d  = cdata_q;
          ack_d   = ~ack_q;
          hit_d   = 1'b0;
          state_d = IDLE;
        end else
`endif
        if (ddram_dout_ready) begin
          dout_d  = ddram_dout;
          ack_d   = ~ack_q;
          state_d = IDLE;
`ifdef SS_DDRAM_RDCACHE_EN
          cvalid_d = 1'b1;
          ctag_d   = tag_q;
          cdata_d  = ddram_dout;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      dout_q  <= '0;
      addr_q  <= BASE_ADDR;
      rd_q    <= 1'b0;
      we_q    <= 1'b0;
      din_q   <= '0;
      be_q    <= {BEW{1'b1}};
`ifdef SS_DDRAM_RDCACHE_EN
      hit_q    <= 1'b0;
      tag_q    <= '0;
      cvalid_q <= 1'b0;
      ctag_q   <= '0;
      cdata_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dout_q  <= dout_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      din_q   <= din_d;
      be_q    <= be_d;
`ifdef SS_DDRAM_RDCACHE_EN
      hit_q    <= hit_d;
      tag_q    <= tag_d;
      cvalid_q <= cvalid_d;
      ctag_q   <= ctag_d;
      cdata_q  <= cdata_d;
`endif
    end
  end

  assign ss_ack         = ack_q;
  assign ss_dout        = dout_q;
  assign ddram_addr     = addr_q;
  assign ddram_burstcnt = 8'd1;
  assign ddram_rd       = rd_q;
  assign ddram_we       = we_q;
  assign ddram_din      = din_q;
  assign ddram_be       = be_q;

endmodule
